// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with a DIRECT (decode A) mode and a
// SCAN mode that walks every output in turn, holding each for DWELL cycles.
module scan_decoder #(
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned DWELL      = 4,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        A,
    output logic [(1<<SEL_W)-1:0]   Y,
    output logic [SEL_W-1:0]        sel_out,
    output logic                    valid,
    output logic                    wrap
);

    localparam int unsigned N     = 1 << SEL_W;
    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);
    localparam logic [N-1:0]     Y_IDLE   = ACTIVE_LOW ? {N{1'b1}} : {N{1'b0}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [SEL_W-1:0]   sel_n;
    logic [N-1:0]       hot, y_n;
    logic               valid_n, wrap_n;

    // State, dwell counter and all outputs are registered together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_out <= '0;
            Y       <= Y_IDLE;
            valid   <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            sel_out <= sel_n;
            Y       <= y_n;
            valid   <= valid_n;
            wrap    <= wrap_n;
        end
    end

    // Next state follows en/mode directly; outputs are computed for that state
    always_comb begin
        state_n = IDLE;
        sel_n   = sel_out;
        cnt_n   = cnt_q;
        valid_n = 1'b0;
        wrap_n  = 1'b0;
        hot     = '0;

        if (en) begin
            state_n = mode ? SCAN : DIRECT;
        end

        case (state_n)
            DIRECT: begin
                sel_n   = A;
                cnt_n   = '0;
                valid_n = 1'b1;
            end
            SCAN: begin
                valid_n = 1'b1;
                if (state_q == DIRECT) begin
                    sel_n = '0;
                    cnt_n = '0;
                end else if (state_q == SCAN) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_n  = '0;
                        sel_n  = sel_out + SEL_W'(1);
                        wrap_n = (sel_out == SEL_LAST);
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
                // entry from IDLE resumes the frozen index and count unchanged
            end
            default: ;
        endcase

        if (valid_n) begin
            hot[sel_n] = 1'b1;
        end
        y_n = hot ^ Y_IDLE;
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: default instance plus ACTIVE_LOW and
// DWELL=1/SEL_W=2 variants driven from shared stimulus.
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic [2:0] A;

    logic [7:0] y;
    logic [2:0] sel;
    logic       valid, wrap;
    logic [7:0] al_y;
    logic [2:0] al_sel;
    logic       al_valid, al_wrap;
    logic [3:0] d1_y;
    logic [1:0] d1_sel;
    logic       d1_valid, d1_wrap;

    int n_vec  = 0;
    int n_miss = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .A(A),
        .Y(y), .sel_out(sel), .valid(valid), .wrap(wrap));

    scan_decoder #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .A(A),
        .Y(al_y), .sel_out(al_sel), .valid(al_valid), .wrap(al_wrap));

    scan_decoder #(.SEL_W(2), .DWELL(1), .ACTIVE_LOW(1'b0)) dut_d1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .A(A[1:0]),
        .Y(d1_y), .sel_out(d1_sel), .valid(d1_valid), .wrap(d1_wrap));

    typedef struct {
        logic       en;
        logic       mode;
        logic [2:0] a;
        logic [7:0] y;
        logic [2:0] sel;
        logic       valid;
    } vec_t;

    function automatic logic [15:0] pk(input logic [7:0] py, input logic [2:0] ps,
                                       input logic pv, input logic pw);
        return {3'b000, py, ps, pv, pw};
    endfunction

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got y=%h sel=%0d valid=%b wrap=%b, required y=%h sel=%0d valid=%b wrap=%b",
                     tag, act[12:5], act[4:2], act[1], act[0], exp[12:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected main-DUT result, then
    // pop and compare it once the registered output has updated.
    task automatic step(input logic e, input logic m, input logic [2:0] a,
                        input logic [7:0] ey, input logic [2:0] es,
                        input logic ev, input logic ew, input string tag);
        en   = e;
        mode = m;
        A    = a;
        exp_q.push_back(pk(ey, es, ev, ew));
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check(tag_q.pop_front(), pk(y, sel, valid, wrap), exp_q.pop_front());
    endtask

    function automatic logic [15:0] d1_act();
        return pk({4'b0000, d1_y}, {1'b0, d1_sel}, d1_valid, d1_wrap);
    endfunction

    function automatic logic [15:0] d1_exp(input int s, input logic w);
        logic [3:0] oh;
        oh = 4'b0001 << s;
        return pk({4'b0000, oh}, 3'(s), 1'b1, w);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[10];
        int   s;
        logic w;
        int   res_sel[7];
        int   d1_res[3];

        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{en: 1'b1, mode: 1'b0, a: 3'(i), y: 8'b1 << i, sel: 3'(i), valid: 1'b1};
        end
        vecs[8] = '{en: 1'b0, mode: 1'b0, a: 3'd3, y: 8'h00, sel: 3'd7, valid: 1'b0};
        vecs[9] = '{en: 1'b1, mode: 1'b0, a: 3'd2, y: 8'h04, sel: 3'd2, valid: 1'b1};

        rst  = 1'b1;
        en   = 1'b0;
        mode = 1'b0;
        A    = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", pk(y, sel, valid, wrap), pk(8'h00, 3'd0, 1'b0, 1'b0));
        check("reset_al", pk(al_y, al_sel, al_valid, al_wrap), pk(8'hFF, 3'd0, 1'b0, 1'b0));
        check("reset_d1", d1_act(), 16'h0000);
        rst = 1'b0;

        // DIRECT sweep, one IDLE cycle, then DIRECT A=2
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].en, vecs[i].mode, vecs[i].a, vecs[i].y, vecs[i].sel, vecs[i].valid, 1'b0, "table");
            check("table_al", pk(al_y, al_sel, al_valid, al_wrap),
                  pk(vecs[i].en ? ~(8'b1 << vecs[i].a) : 8'hFF, vecs[i].sel, vecs[i].valid, 1'b0));
        end

        // SCAN walk from DIRECT; ends at index 5 with the counter at 2
        for (int k = 0; k <= 86; k++) begin
            s = (k / 4) % 8;
            w = (k == 32) || (k == 64);
            step(1'b1, 1'b1, 3'd0, 8'b1 << s, 3'(s), 1'b1, w, "scan_walk");
            if (k <= 40) begin
                check("scan_d1", d1_act(), d1_exp(k % 4, (k > 0) && (k % 4 == 0)));
            end
        end

        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 3'd0, 8'h00, 3'd5, 1'b0, 1'b0, "freeze");
        end
        check("freeze_d1", d1_act(), pk(8'h00, 3'd2, 1'b0, 1'b0));

        res_sel = '{5, 5, 6, 6, 6, 6, 7};
        d1_res  = '{2, 3, 0};
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, 3'd0, 8'b1 << res_sel[i], 3'(res_sel[i]), 1'b1, 1'b0, "resume");
            if (i < 3) begin
                check("resume_d1", d1_act(), d1_exp(d1_res[i], i == 2));
            end
        end

        // Mode switch: DIRECT, scan to index 3, DIRECT A=6, back to SCAN
        step(1'b1, 1'b0, 3'd1, 8'h02, 3'd1, 1'b1, 1'b0, "direct_pre");
        for (int k = 0; k <= 13; k++) begin
            s = k / 4;
            step(1'b1, 1'b1, 3'd0, 8'b1 << s, 3'(s), 1'b1, 1'b0, "scan_to_3");
        end
        step(1'b1, 1'b0, 3'd6, 8'h40, 3'd6, 1'b1, 1'b0, "mode_switch");
        for (int k = 0; k <= 4; k++) begin
            s = k / 4;
            step(1'b1, 1'b1, 3'd0, 8'b1 << s, 3'(s), 1'b1, 1'b0, "rescan");
        end

        // Asynchronous reset between edges while scanning
        #3;
        rst = 1'b1;
        #1;
        check("async_rst", pk(y, sel, valid, wrap), pk(8'h00, 3'd0, 1'b0, 1'b0));
        check("async_rst_al", pk(al_y, al_sel, al_valid, al_wrap), pk(8'hFF, 3'd0, 1'b0, 1'b0));
        check("async_rst_d1", d1_act(), 16'h0000);
        @(posedge clk);
        #1;
        check("rst_held", pk(y, sel, valid, wrap), pk(8'h00, 3'd0, 1'b0, 1'b0));
        rst = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            s = k / 4;
            step(1'b1, 1'b1, 3'd0, 8'b1 << s, 3'(s), 1'b1, 1'b0, "post_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
